node_allocator: RTL and testbench
=================================

# node_allocator

Central scheduler that hands out the nine mesh NoC nodes (3x3, node IDs 0–8) to software/host requesters and tracks which nodes are busy. Requesters ask for a node with a valid/ready handshake. The allocator round-robins between requesters, picks the lowest-index free node, and returns its ID. Owners later release the node. The per-node availability vector drives the NoC's core-availability inputs, and the granted ID feeds node start/dispatch logic.

## Interface
Parameters:
- `NODES`, 9: number of allocatable nodes.
- `REQ`, 4: number of requesters.
- `ID_W`, `$clog2(NODES)` (4): node ID width.
- `TIMEOUT`, 1024: watchdog limit in cycles; used only with the configuration macro.

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  REQ  — per-requester allocation request; held until acknowledged.
- `req_ready`  out  REQ  — one-hot acknowledge, single-cycle pulse.
- `grant_valid`  out  1  — high in the same cycle as `req_ready`.
- `grant_req`  out  `$clog2(REQ)`  — index of the granted requester.
- `grant_node`  out  ID_W  — allocated node ID.
- `rel_valid`  in  1  — release strobe.
- `rel_node`  in  ID_W  — node to release.
- `rel_err`  out  1  — pulse: release of a free or out-of-range node.
- `node_avail`  out  NODES  — bit i = 1 when node i is free.
- `busy_count`  out  `$clog2(NODES+1)`  — number of busy nodes.
- `timeout_valid`  out  1  — watchdog forced-release pulse.
- `timeout_node`  out  ID_W  — node force-released.

## Operation
- Two-state FSM: ARB and GRANT.
- **ARB**
  - Arbitration only starts if any `req_valid` bit is set and `node_avail` is nonzero.
  - Requester choice is round-robin, starting at `rr_ptr`.
  - Node choice is the lowest-index free node.
  - On a win: register requester and node, mark the node busy, set `rr_ptr` to winner+1 mod REQ, then go to GRANT.
- **GRANT**
  - For exactly one cycle, assert `req_ready[winner]`, `grant_valid`, `grant_req` and `grant_node`.
  - Return to ARB on the next cycle.
- **Release**
  - Valid in any state.
  - A legal release (`rel_node` < NODES and node busy) clears the busy bit on the next edge.
  - An illegal release leaves state unchanged and pulses `rel_err` one cycle later.
- **Simultaneous release and arbitration:** ARB uses the registered busy map, so a node released in cycle N is allocatable from cycle N+1.
- **All nodes busy:** requests wait in ARB indefinitely. `req_ready` stays 0.
- **Protocol:** a requester that drops `req_valid` during GRANT still owns the node. This is the requester's protocol violation, and the allocator does not check for it.
- `busy_count` always equals the popcount of `~node_avail`. It is updated in the same cycle as the map.

## Timing
- Reset values:
  - State ARB, `rr_ptr`=0.
  - `node_avail` all 1, `busy_count` 0.
  - `req_ready`, `grant_valid`, `rel_err`, `timeout_valid` all 0.
  - `grant_req`, `grant_node`, `timeout_node` all 0.
- Reset asserted mid-GRANT aborts the grant. No `req_ready` pulse is emitted and all nodes become free.
- Grant latency is 1 cycle: request sampled in ARB at edge N, `req_ready` high during cycle N+1.
- Peak throughput is one grant per 2 cycles.
- In `node_avail`, a node shows busy starting in the GRANT cycle and shows free one cycle after a legal `rel_valid`.

## Configuration
- Macro: `NODE_ALLOC_TIMEOUT_EN`.
- **Defined**
  - Each node has a counter of `$clog2(TIMEOUT+1)` bits.
  - The counter is cleared on grant and increments while the node is busy.
  - When it reaches TIMEOUT, the node is freed on the next edge and `timeout_valid`/`timeout_node` pulse for one cycle.
  - If several nodes expire in the same cycle, the lowest index is handled first and the others follow on successive cycles; their counters saturate at TIMEOUT.
  - A legal release that coincides with expiry wins: the node is freed and no timeout pulse is produced.
- **Undefined:** no counters are built; `timeout_valid` and `timeout_node` are tied to 0.

## Structure
- Package `node_alloc_pkg` holds:
  - `NODES`, `ID_W`.
  - `typedef logic [ID_W-1:0] node_id_t`.
  - FSM `typedef enum logic {ARB, GRANT} alloc_state_t`.
- Sub-module `rr_arbiter`:
  - Parameter REQ; inputs `req`, `ptr`.
  - Outputs one-hot `gnt`, `gnt_idx`, `any`.
  - Purely combinational; instantiated once.
- Lowest-free-node priority encoder stays inline.

## Test plan
- **Reset, then single request:** after reset, `req_valid`=4'b0001 → `req_ready`=0001 one cycle later, `grant_node`=0, `node_avail`=9'h1FE, `busy_count`=1.
- **Round-robin:** hold `req_valid`=4'b1111 → grants go to requesters 0,1,2,3,0 on nodes 0,1,2,3,4, spaced 2 cycles apart.
- **Exhaustion and refill:** allocate all 9 nodes (`busy_count`=9); the 10th request stalls. `rel_valid` with `rel_node`=5 → the stalled requester gets node 5 two cycles after the release.
- **Illegal release:** `rel_node`=7 while free → `rel_err` pulses, map unchanged. `rel_node`=12 → `rel_err` pulses.
- **Reset mid-GRANT:** assert `rst` in the GRANT cycle → no `req_ready`, `node_avail`=9'h1FF, `rr_ptr`=0.
- **Watchdog (`NODE_ALLOC_TIMEOUT_EN`, TIMEOUT=16):** grant node 0 with no release → `timeout_valid`=1, `timeout_node`=0 after 16 busy cycles; node 0 is free next cycle. A release in the expiry cycle → no timeout pulse.

Source files
------------

// File: rtl/node_alloc_pkg.sv
// Shared types and constants for the mesh node allocator.
package node_alloc_pkg;

    localparam int unsigned NODES      = 9;
    localparam int unsigned ID_W       = $clog2(NODES);
    localparam int unsigned BUSY_CNT_W = $clog2(NODES + 1);

    typedef logic [ID_W-1:0]  node_id_t;
    typedef logic [NODES-1:0] node_map_t;

    typedef enum logic {ARB, GRANT} alloc_state_t;

    // Number of busy nodes in an availability map (bit set = free).
    function automatic logic [BUSY_CNT_W-1:0] busy_popcount(input node_map_t avail);
        logic [BUSY_CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NODES; i++) begin
            if (!avail[i]) begin
                n = n + BUSY_CNT_W'(1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/node_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter  int unsigned REQ   = 4,
    localparam int unsigned IDX_W = $clog2(REQ)
) (
    input  logic [REQ-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic [REQ-1:0]   gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned off);
        return IDX_W'((32'(base) + off) % REQ);
    endfunction

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int unsigned off = 0; off < REQ; off++) begin
            if (!any && req[wrap_idx(ptr, off)]) begin
                any                     = 1'b1;
                gnt_idx                 = wrap_idx(ptr, off);
                gnt[wrap_idx(ptr, off)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/node_allocator.sv
// Hands out free mesh nodes to round-robin requesters and tracks the busy map.
// Optional per-node watchdog enabled by defining NODE_ALLOC_TIMEOUT_EN.
module node_allocator
    import node_alloc_pkg::*;
#(
    parameter  int unsigned REQ     = 4,
    parameter  int unsigned TIMEOUT = 1024,
    localparam int unsigned REQ_W   = $clog2(REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REQ-1:0]        req_valid,
    output logic [REQ-1:0]        req_ready,
    output logic                  grant_valid,
    output logic [REQ_W-1:0]      grant_req,
    output logic [ID_W-1:0]       grant_node,
    input  logic                  rel_valid,
    input  logic [ID_W-1:0]       rel_node,
    output logic                  rel_err,
    output logic [NODES-1:0]      node_avail,
    output logic [BUSY_CNT_W-1:0] busy_count,
    output logic                  timeout_valid,
    output logic [ID_W-1:0]       timeout_node
);

    alloc_state_t          r_state;
    alloc_state_t          w_state_nxt;
    logic [REQ_W-1:0]      r_rr_ptr;
    logic [REQ_W-1:0]      w_rr_ptr_nxt;
    node_map_t             r_avail;
    node_map_t             w_avail_nxt;
    logic [BUSY_CNT_W-1:0] r_busy_count;
    logic [REQ-1:0]        r_req_ready;
    logic [REQ-1:0]        w_req_ready_nxt;
    logic                  r_grant_valid;
    logic                  w_grant_valid_nxt;
    logic [REQ_W-1:0]      r_grant_req;
    logic [REQ_W-1:0]      w_grant_req_nxt;
    node_id_t              r_grant_node;
    node_id_t              w_grant_node_nxt;
    logic                  r_rel_err;
    logic                  w_rel_err_nxt;

    logic [REQ-1:0]        w_arb_gnt;
    logic [REQ_W-1:0]      w_arb_idx;
    logic                  w_arb_any;
    logic                  w_free_any;
    node_id_t              w_free_idx;
    logic                  w_win;
    logic                  w_rel_legal;
    node_map_t             w_rel_mask;
    logic                  w_to_hit;
    node_id_t              w_to_idx;

    if (TIMEOUT == 0) begin : g_timeout_chk
        $error("node_allocator: TIMEOUT must be nonzero");
    end

    rr_arbiter #(
        .REQ (REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_arb_gnt),
        .gnt_idx (w_arb_idx),
        .any     (w_arb_any)
    );

    // Lowest-index free node.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int unsigned i = 0; i < NODES; i++) begin
            if (!w_free_any && r_avail[i]) begin
                w_free_any = 1'b1;
                w_free_idx = ID_W'(i);
            end
        end
    end

    assign w_win       = (r_state == ARB) && w_arb_any && w_free_any;
    assign w_rel_legal = rel_valid && (rel_node < ID_W'(NODES)) && !r_avail[rel_node];
    assign w_rel_mask  = w_rel_legal ? (node_map_t'(1) << rel_node) : '0;

`ifdef NODE_ALLOC_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_age [NODES];
    node_map_t       w_expired;
    logic            r_timeout_valid;
    node_id_t        r_timeout_node;

    // A legal release in the expiry cycle takes precedence over the watchdog.
    always_comb begin
        w_expired = '0;
        for (int unsigned i = 0; i < NODES; i++) begin
            w_expired[i] = !r_avail[i] && (r_age[i] == TO_W'(TIMEOUT)) && !w_rel_mask[i];
        end
    end

    always_comb begin
        w_to_hit = 1'b0;
        w_to_idx = '0;
        for (int unsigned i = NODES; i > 0; i--) begin
            if (w_expired[i-1]) begin
                w_to_hit = 1'b1;
                w_to_idx = ID_W'(i - 1);
            end
        end
    end

    // Age saturates at TIMEOUT so queued expiries wait their turn.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NODES; i++) begin
            if (rst) begin
                r_age[i] <= '0;
            end else if (w_win && (w_free_idx == ID_W'(i))) begin
                r_age[i] <= '0;
            end else if (!r_avail[i] && (r_age[i] != TO_W'(TIMEOUT))) begin
                r_age[i] <= r_age[i] + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_valid <= 1'b0;
            r_timeout_node  <= '0;
        end else begin
            r_timeout_valid <= w_to_hit;
            if (w_to_hit) begin
                r_timeout_node <= w_to_idx;
            end
        end
    end

    assign timeout_valid = r_timeout_valid;
    assign timeout_node  = r_timeout_node;
`else
    assign w_to_hit      = 1'b0;
    assign w_to_idx      = '0;
    assign timeout_valid = 1'b0;
    assign timeout_node  = '0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_avail_nxt       = r_avail;
        w_req_ready_nxt   = '0;
        w_grant_valid_nxt = 1'b0;
        w_grant_req_nxt   = r_grant_req;
        w_grant_node_nxt  = r_grant_node;
        w_rel_err_nxt     = rel_valid && !w_rel_legal;

        case (r_state)
            ARB: begin
                if (w_win) begin
                    w_state_nxt              = GRANT;
                    w_req_ready_nxt          = w_arb_gnt;
                    w_grant_valid_nxt        = 1'b1;
                    w_grant_req_nxt          = w_arb_idx;
                    w_grant_node_nxt         = w_free_idx;
                    w_avail_nxt[w_free_idx]  = 1'b0;
                    w_rr_ptr_nxt             = REQ_W'((32'(w_arb_idx) + 1) % REQ);
                end
            end
            GRANT: begin
                w_state_nxt = ARB;
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase

        w_avail_nxt = w_avail_nxt | w_rel_mask;
        if (w_to_hit) begin
            w_avail_nxt[w_to_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_avail       <= '1;
            r_busy_count  <= '0;
            r_req_ready   <= '0;
            r_grant_valid <= 1'b0;
            r_grant_req   <= '0;
            r_grant_node  <= '0;
            r_rel_err     <= 1'b0;
        end else begin
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_avail       <= w_avail_nxt;
            r_busy_count  <= busy_popcount(w_avail_nxt);
            r_req_ready   <= w_req_ready_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_req   <= w_grant_req_nxt;
            r_grant_node  <= w_grant_node_nxt;
            r_rel_err     <= w_rel_err_nxt;
        end
    end

    // Reset during the grant cycle withdraws the acknowledge: the node it names is being freed.
    assign req_ready   = rst ? '0 : r_req_ready;
    assign grant_valid = r_grant_valid && !rst;
    assign grant_req   = r_grant_req;
    assign grant_node  = r_grant_node;
    assign rel_err     = r_rel_err;
    assign node_avail  = r_avail;
    assign busy_count  = r_busy_count;

endmodule

// File: tb/tb_node_allocator.sv
// Randomized self-checking bench for node_allocator against a behavioural model.
module tb_node_allocator;

    localparam int NN = 9;
    localparam int NR = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic       grant_valid;
    logic [1:0] grant_req;
    logic [3:0] grant_node;
    logic       rel_valid;
    logic [3:0] rel_node;
    logic       rel_err;
    logic [8:0] node_avail;
    logic [3:0] busy_count;
    logic       timeout_valid;
    logic [3:0] timeout_node;

    node_allocator #(
        .REQ     (4),
        .TIMEOUT (1024)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .grant_valid   (grant_valid),
        .grant_req     (grant_req),
        .grant_node    (grant_node),
        .rel_valid     (rel_valid),
        .rel_node      (rel_node),
        .rel_err       (rel_err),
        .node_avail    (node_avail),
        .busy_count    (busy_count),
        .timeout_valid (timeout_valid),
        .timeout_node  (timeout_node)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: free map, rotating pointer, and whether the current cycle is a grant pulse.
    bit [8:0] m_avail  = '1;
    int       m_ptr    = 0;
    bit       m_gcyc   = 1'b0;
    int       m_greq   = 0;
    int       m_gnode  = 0;
    bit       m_relerr = 1'b0;
    bit       chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int count_busy(input bit [8:0] a);
        int n = 0;
        for (int i = 0; i < NN; i++) if (!a[i]) n++;
        return n;
    endfunction

    task automatic model_step();
        bit [8:0] nxt;
        int w;
        int n;
        if (rst) begin
            m_avail = '1; m_ptr = 0; m_gcyc = 0; m_greq = 0; m_gnode = 0; m_relerr = 0;
            return;
        end
        nxt = m_avail;
        w = -1;
        n = -1;
        if (!m_gcyc && req_valid != 0 && m_avail != 0) begin
            for (int k = 0; k < NR; k++) if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            for (int i = 0; i < NN; i++) if (n < 0 && m_avail[i]) n = i;
            nxt[n]  = 1'b0;
            m_ptr   = (w + 1) % NR;
            m_greq  = w;
            m_gnode = n;
        end
        m_gcyc   = (w >= 0);
        m_relerr = 1'b0;
        if (rel_valid) begin
            if (int'(rel_node) < NN && !m_avail[rel_node]) nxt[rel_node] = 1'b1;
            else m_relerr = 1'b1;
        end
        m_avail = nxt;
    endtask

    // Advance one clock; inputs are applied 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit gv;
            gv = m_gcyc && !rst;
            check("req_ready", int'(req_ready), gv ? (1 << m_greq) : 0);
            check("grant_valid", int'(grant_valid), int'(gv));
            if (gv) begin
                check("grant_req", int'(grant_req), m_greq);
                check("grant_node", int'(grant_node), m_gnode);
            end
            check("rel_err", int'(rel_err), int'(m_relerr));
            check("node_avail", int'(node_avail), int'(m_avail));
            check("busy_count", int'(busy_count), count_busy(m_avail));
            check("timeout_valid", int'(timeout_valid), 0);
            check("timeout_node", int'(timeout_node), 0);
        end
    end

    initial begin
        bit [3:0] drop;
        int       nb;
        int       pick;

        rst = 1'b1; req_valid = '0; rel_valid = 1'b0; rel_node = '0;
        tick();
        chk_en = 1'b1;
        tick();

        // Reset state, then a single request
        rst = 1'b0;
        check("rst_avail", int'(node_avail), 'h1FF);
        check("rst_busy", int'(busy_count), 0);
        check("rst_ready", int'(req_ready), 0);
        req_valid = 4'b0001;
        tick();
        check("single_ready", int'(req_ready), 1);
        check("single_node", int'(grant_node), 0);
        check("single_avail", int'(node_avail), 'h1FE);
        check("single_busy", int'(busy_count), 1);
        req_valid = '0;
        tick();
        check("single_done", int'(req_ready), 0);

        // Round-robin to exhaustion, stall, then refill from a release
        do_reset();
        req_valid = 4'b1111;
        for (int g = 0; g < NN; g++) begin
            tick();
            check("rr_ready", int'(req_ready), 1 << (g % NR));
            check("rr_node", int'(grant_node), g);
            tick();
            check("rr_gap", int'(grant_valid), 0);
        end
        check("full_busy", int'(busy_count), 9);
        check("full_avail", int'(node_avail), 0);
        repeat (4) tick();
        check("stall_ready", int'(req_ready), 0);
        rel_valid = 1'b1; rel_node = 4'd5;
        tick();
        rel_valid = 1'b0;
        check("rel_free", int'(node_avail), 'h020);
        tick();
        check("refill_ready", int'(req_ready), 4'b0010);
        check("refill_node", int'(grant_node), 5);
        req_valid = '0;
        tick();

        // Illegal releases
        do_reset();
        rel_valid = 1'b1; rel_node = 4'd7;
        tick();
        rel_node = 4'd12;
        check("illeg7_err", int'(rel_err), 1);
        check("illeg7_map", int'(node_avail), 'h1FF);
        tick();
        rel_valid = 1'b0;
        check("illeg12_err", int'(rel_err), 1);
        tick();
        check("illeg_clear", int'(rel_err), 0);

        // Reset during the grant cycle
        do_reset();
        req_valid = 4'b0001;
        tick();
        check("pre_rst_ready", int'(req_ready), 1);
        rst = 1'b1;
        #1;
        check("rst_grant_ready", int'(req_ready), 0);
        check("rst_grant_valid", int'(grant_valid), 0);
        req_valid = '0;
        tick();
        check("rst_grant_avail", int'(node_avail), 'h1FF);
        check("rst_grant_busy", int'(busy_count), 0);
        rst = 1'b0;
        req_valid = 4'b1111;
        tick();
        check("ptr_after_rst", int'(req_ready), 1);
        req_valid = '0;
        tick();

        // Randomized traffic: requesters hold until acknowledged, owners release at random
        do_reset();
        drop = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            req_valid = req_valid & ~drop;
            drop = '0;
            if (m_gcyc && !rst) drop = 4'(1 << m_greq);
            for (int r = 0; r < NR; r++) if ($urandom_range(0, 2) == 0) req_valid[r] = 1'b1;
            rel_valid = ($urandom_range(0, 2) == 0);
            nb = count_busy(m_avail);
            if (nb > 0 && $urandom_range(0, 6) != 0) begin
                pick = $urandom_range(0, nb - 1);
                for (int i = 0; i < NN; i++) begin
                    if (!m_avail[i]) begin
                        if (pick == 0) rel_node = 4'(i);
                        pick--;
                    end
                end
            end else begin
                rel_node = 4'($urandom_range(0, 15));
            end
            tick();
        end
        rst = 1'b0; req_valid = '0; rel_valid = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
